// File: rtl/fetch.sv
// fetch: 6502 instruction fetch stage feeding the opcode decoder and execute sequencer
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0400
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic [7:0]  dec_opcode,
  input  logic [4:0]  dec_op_type,
  input  logic        dec_single_byte,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [15:0] ins_operand,
  output logic [1:0]  ins_len,
  output logic [15:0] ins_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);
  localparam logic [4:0] OP_IMP = 5'd0, OP_ABS = 5'd4, OP_AXY = 5'd5, OP_JUM = 5'd8,
                         OP_JIN = 5'd9, OP_JSR = 5'd10, OP_RTS = 5'd11, OP_RTI = 5'd12,
                         OP_PUS = 5'd14, OP_PUL = 5'd15, OP_JAM = 5'd16;
  typedef enum logic [2:0] {S_OP, S_LEN, S_LO, S_HI, S_HOLD} state_t;
  state_t      st_q, st_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d, opd_q, opd_d, ipc_q, ipc_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  len_q, len_d, len_f;
  logic        out_q, out_d, kill_q, kill_d, rd_q, rd_d, vld_q, vld_d, take;
  // Instruction length from the decoder classification; single_byte overrides everything
  always_comb
    len_f = (dec_single_byte || dec_op_type inside {OP_RTI, OP_RTS, OP_PUS, OP_PUL, OP_IMP, OP_JAM}) ? 2'd1 :
            (dec_op_type inside {OP_ABS, OP_AXY, OP_JUM, OP_JIN, OP_JSR}) ? 2'd3 : 2'd2;
  // Next-state: byte capture, length evaluation, handshake, redirect (highest priority), read issue
  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    out_d  = out_q;
    kill_d = kill_q;
    op_d   = op_q;
    opd_d  = opd_q;
    len_d  = len_q;
    ipc_d  = ipc_q;
    take   = mem_rvalid && out_q && !kill_q && !redirect;
    if (mem_rvalid) begin
      out_d  = 1'b0;
      kill_d = 1'b0;
    end
    if (take) begin
      pc_d = pc_q + 16'd1;
      case (st_q)
        S_OP: begin
          op_d  = mem_rdata;
          ipc_d = pc_q;
          opd_d = '0;
          st_d  = S_LEN;
        end
        S_LO: begin
          opd_d[7:0] = mem_rdata;
          st_d       = (len_q == 2'd3) ? S_HI : S_HOLD;
        end
        S_HI: begin
          opd_d[15:8] = mem_rdata;
          st_d        = S_HOLD;
        end
        default: ;
      endcase
    end
    if (st_q == S_LEN) begin
      len_d = len_f;
      st_d  = (len_f == 2'd1) ? S_HOLD : S_LO;
    end
    if (st_q == S_HOLD && ins_ready) st_d = S_OP;
    if (redirect) begin
      pc_d   = redirect_pc;
      st_d   = S_OP;
      kill_d = out_q && !mem_rvalid;
    end
    rd_d   = (st_d == S_OP || st_d == S_LO || st_d == S_HI) && !out_d && !rd_q;
    if (rd_d) out_d = 1'b1;
    addr_d = rd_d ? pc_d : addr_q;
    vld_d  = st_d == S_HOLD;
  end
  // State and registered outputs; reset abandons any outstanding read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_OP;
      pc_q   <= RESET_PC;
      out_q  <= 1'b0;
      kill_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      op_q   <= '0;
      opd_q  <= '0;
      len_q  <= '0;
      ipc_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      out_q  <= out_d;
      kill_q <= kill_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      op_q   <= op_d;
      opd_q  <= opd_d;
      len_q  <= len_d;
      ipc_q  <= ipc_d;
      vld_q  <= vld_d;
    end
  end
  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign dec_opcode  = op_q;
  assign ins_valid   = vld_q;
  assign ins_opcode  = op_q;
  assign ins_operand = opd_q;
  assign ins_len     = len_q;
  assign ins_pc      = ipc_q;
endmodule
